// File: rtl/skolem_chk_pkg.sv
// Shared types and helpers for the bvugt/bvurem1 Skolem sweep checker.
package skolem_chk_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DIV     = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6
  } state_t;

  // Invertibility condition of (s urem x) >u t: a witness exists iff t <u s.
  function automatic logic ic_ugt_urem1(input logic [W_DEF-1:0] s,
                                        input logic [W_DEF-1:0] t);
    return (t < s);
  endfunction

endpackage

// File: rtl/skolem_urem_seq.sv
// Sequential restoring divider returning dividend urem divisor in W cycles;
// a zero divisor yields the dividend (SMT-LIB semantics).
module skolem_urem_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic         done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  shf_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  dvd_q;
  logic          zero_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  logic [W-1:0]  src_rem;
  logic [W-1:0]  src_bits;
  logic [W-1:0]  src_dvs;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  shf_step;

  // The first step runs on the start edge straight from the inputs, so the
  // last of the W steps lands while done is being raised.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_bits = start ? dividend : shf_q;
    src_dvs  = start ? divisor : dvs_q;
    trial    = {src_rem, src_bits[W-1]};
    ge       = (trial >= {1'b0, src_dvs});
    rem_step = ge ? W'(trial - {1'b0, src_dvs}) : trial[W-1:0];
    shf_step = {src_bits[W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      shf_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_step;
      shf_q  <= shf_step;
      dvs_q  <= divisor;
      dvd_q  <= dividend;
      zero_q <= (divisor == '0);
      cnt_q  <= CNT_LOAD;
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_step;
      shf_q  <= shf_step;
      cnt_q  <= cnt_q - CNT_ONE;
      done_q <= (cnt_q == CNT_ONE);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign rem  = zero_q ? dvd_q : rem_q;
  assign done = done_q;

endmodule

// File: rtl/skolem_ic_sweep_checker.sv
// Exhaustive checker for an external bvugt/bvurem1 Skolem netlist x = f(s,t).
// Build option: SKOLEM_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first failure.
//
// state   | meaning
// IDLE    | waiting for start_i after reset
// DRIVE   | register {t,s} of the current vector onto uut_in_o
// WAIT    | SETTLE cycles for the netlist to settle
// CAPTURE | sample x_i and launch the divider
// DIV     | W-cycle s urem x
// CHECK   | score the vector, advance or finish
// DONE    | results held until the next start_i
module skolem_ic_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  output logic [2*W-1:0] uut_in_o,
  input  logic [W-1:0]   x_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [2*W:0]   fail_cnt_o,
  output logic [2*W:0]   skip_cnt_o,
  output logic [2*W-1:0] ff_vec_o,
  output logic [W-1:0]   ff_x_o
);

  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0]  TMR_LOAD = TW'(SETTLE - 1);
  localparam logic [TW-1:0]  TMR_ONE  = TW'(1);
  localparam logic [2*W:0]   CNT_ONE  = (2*W+1)'(1);
  localparam logic [2*W:0]   CNT_MAX  = {1'b1, {(2*W){1'b0}}};
  localparam logic [2*W-1:0] IDX_ONE  = (2*W)'(1);

  state_t state_q, state_d;

  logic [2*W-1:0] idx_q;
  logic [2*W-1:0] uut_q;
  logic [W-1:0]   x_q;
  logic [TW-1:0]  tmr_q;
  logic [2*W:0]   fail_cnt_q;
  logic [2*W:0]   skip_cnt_q;
  logic [2*W-1:0] ff_vec_q;
  logic [W-1:0]   ff_x_q;

  logic [W-1:0] s_cur;
  logic [W-1:0] t_cur;
  logic [W-1:0] div_rem;
  logic         div_done;
  logic         ic;
  logic         bad;

  logic clr, load_uut, tmr_load, tmr_dec, cap, div_start;
  logic inc_skip, inc_fail, latch_ff, idx_inc;

  assign s_cur = uut_q[W-1:0];
  assign t_cur = uut_q[2*W-1:W];

  skolem_urem_seq #(.W(W)) u_urem (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (s_cur),
    .divisor  (x_i),
    .rem      (div_rem),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    load_uut  = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    cap       = 1'b0;
    div_start = 1'b0;
    inc_skip  = 1'b0;
    inc_fail  = 1'b0;
    latch_ff  = 1'b0;
    idx_inc   = 1'b0;
    ic        = ic_ugt_urem1(s_cur, t_cur);
    bad       = ic && !(div_rem > t_cur);
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          clr     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        load_uut = 1'b1;
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tmr_q == '0) state_d = CAPTURE;
        else             tmr_dec = 1'b1;
      end
      CAPTURE: begin
        cap       = 1'b1;
        div_start = 1'b1;
        state_d   = DIV;
      end
      DIV: begin
        if (div_done) state_d = CHECK;
      end
      CHECK: begin
        inc_skip = !ic;
        inc_fail = bad;
        latch_ff = bad && (fail_cnt_q == '0);
        if (idx_q == '1) begin
          state_d = DONE;
        end else begin
          idx_inc = 1'b1;
          state_d = DRIVE;
        end
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        if (bad) begin
          idx_inc = 1'b0;
          state_d = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      uut_q      <= '0;
      x_q        <= '0;
      tmr_q      <= '0;
      fail_cnt_q <= '0;
      skip_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_x_q     <= '0;
    end else begin
      if (clr) begin
        idx_q      <= '0;
        fail_cnt_q <= '0;
        skip_cnt_q <= '0;
        ff_vec_q   <= '0;
        ff_x_q     <= '0;
      end
      if (load_uut) uut_q <= idx_q;
      if (tmr_load)     tmr_q <= TMR_LOAD;
      else if (tmr_dec) tmr_q <= tmr_q - TMR_ONE;
      if (cap) x_q <= x_i;
      if (inc_skip && (skip_cnt_q != CNT_MAX)) skip_cnt_q <= skip_cnt_q + CNT_ONE;
      if (inc_fail && (fail_cnt_q != CNT_MAX)) fail_cnt_q <= fail_cnt_q + CNT_ONE;
      if (latch_ff) begin
        ff_vec_q <= uut_q;
        ff_x_q   <= x_q;
      end
      if (idx_inc) idx_q <= idx_q + IDX_ONE;
    end
  end

  assign uut_in_o   = uut_q;
  assign busy_o     = (state_q != IDLE) && (state_q != DONE);
  assign done_o     = (state_q == DONE);
  assign pass_o     = done_o && (fail_cnt_q == '0);
  assign fail_cnt_o = fail_cnt_q;
  assign skip_cnt_o = skip_cnt_q;
  assign ff_vec_o   = ff_vec_q;
  assign ff_x_o     = ff_x_q;

endmodule

// File: tb/tb_skolem_ic_sweep_checker.sv
// Directed bench for skolem_ic_sweep_checker with behavioural netlist stand-ins on x_i.
module tb_skolem_ic_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] uut_in_o;
  logic [3:0] x_i;
  logic       busy_o, done_o, pass_o;
  logic [8:0] fail_cnt_o, skip_cnt_o;
  logic [7:0] ff_vec_o;
  logic [3:0] ff_x_o;

  int mode = 0;
  int n_vec = 0;
  int n_err = 0;

`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
  localparam int X1_CYC = 16, X1_FAIL = 1,   X1_SKIP = 1;
  localparam int X3_CYC = 32, X3_FAIL = 1,   X3_SKIP = 1;
  localparam int X7_CYC = 64, X7_FAIL = 1,   X7_SKIP = 1;
`else
  localparam int X1_CYC = 2048, X1_FAIL = 120, X1_SKIP = 136;
  localparam int X3_CYC = 2048, X3_FAIL = 105, X3_SKIP = 136;
  localparam int X7_CYC = 2048, X7_FAIL = 77,  X7_SKIP = 136;
`endif

  skolem_ic_sweep_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .uut_in_o   (uut_in_o),
    .x_i        (x_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_cnt_o (fail_cnt_o),
    .skip_cnt_o (skip_cnt_o),
    .ff_vec_o   (ff_vec_o),
    .ff_x_o     (ff_x_o)
  );

  always #5 clk = ~clk;

  // mode 0 is a correct Skolem function: x = s+1 (s=15 wraps to x=0, rem=s).
  always_comb begin
    case (mode)
      0:       x_i = uut_in_o[3:0] + 4'd1;
      1:       x_i = 4'd1;
      2:       x_i = 4'd0;
      3:       x_i = 4'd3;
      4:       x_i = 4'd7;
      default: x_i = 4'd0;
    endcase
  end

  task automatic run_sweep(output int cyc);
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_o, done_o, pass_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {busy_o, done_o, pass_o});
    end
    n_vec++;
    if ({fail_cnt_o, skip_cnt_o} !== 18'd0) begin
      n_err++; $display("FAIL reset_counts: got fail %0d skip %0d expected 0 0", fail_cnt_o, skip_cnt_o);
    end
    n_vec++;
    if ({uut_in_o, ff_vec_o, ff_x_o} !== 20'd0) begin
      n_err++; $display("FAIL reset_vecs: got uut %h ff %h x %h expected 0", uut_in_o, ff_vec_o, ff_x_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_skolem_netlist;
    int cyc;
    mode = 0;
    run_sweep(cyc);
    n_vec++;
    if (cyc !== 2048) begin n_err++; $display("FAIL netlist_cycles: got %0d expected 2048", cyc); end
    n_vec++;
    if ({busy_o, pass_o} !== 2'b01) begin
      n_err++; $display("FAIL netlist_flags: got busy %b pass %b expected 0 1", busy_o, pass_o);
    end
    n_vec++;
    if (fail_cnt_o !== 9'd0 || skip_cnt_o !== 9'd136) begin
      n_err++; $display("FAIL netlist_counts: got fail %0d skip %0d expected 0 136", fail_cnt_o, skip_cnt_o);
    end
    n_vec++;
    if (ff_vec_o !== 8'h00 || ff_x_o !== 4'h0) begin
      n_err++; $display("FAIL netlist_ff: got %h/%h expected 00/0", ff_vec_o, ff_x_o);
    end
  endtask

  task automatic test_const_witness(input int m, input logic [3:0] xv, input int ecyc,
                                    input int efail, input int eskip, input logic [7:0] effv);
    int cyc;
    mode = m;
    run_sweep(cyc);
    n_vec++;
    if (cyc !== ecyc) begin n_err++; $display("FAIL x%0d_cycles: got %0d expected %0d", xv, cyc, ecyc); end
    n_vec++;
    if (pass_o !== 1'b0 || done_o !== 1'b1) begin
      n_err++; $display("FAIL x%0d_flags: got done %b pass %b expected 1 0", xv, done_o, pass_o);
    end
    n_vec++;
    if (fail_cnt_o !== 9'(efail) || skip_cnt_o !== 9'(eskip)) begin
      n_err++; $display("FAIL x%0d_counts: got fail %0d skip %0d expected %0d %0d",
                        xv, fail_cnt_o, skip_cnt_o, efail, eskip);
    end
    n_vec++;
    if (ff_vec_o !== effv || ff_x_o !== xv) begin
      n_err++; $display("FAIL x%0d_ff: got %h/%h expected %h/%h", xv, ff_vec_o, ff_x_o, effv, xv);
    end
  endtask

  task automatic test_x_zero;
    int cyc;
    mode = 2;
    run_sweep(cyc);
    n_vec++;
    if (cyc !== 2048) begin n_err++; $display("FAIL x0_cycles: got %0d expected 2048", cyc); end
    n_vec++;
    if (pass_o !== 1'b1 || fail_cnt_o !== 9'd0 || skip_cnt_o !== 9'd136) begin
      n_err++; $display("FAIL x0_result: got pass %b fail %0d skip %0d expected 1 0 136",
                        pass_o, fail_cnt_o, skip_cnt_o);
    end
  endtask

  // Restart straight from DONE after a failing run: results must clear at once.
  task automatic test_back_to_back;
    int cyc;
    mode = 2;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    n_vec++;
    if (fail_cnt_o !== 9'd0 || skip_cnt_o !== 9'd0 || ff_vec_o !== 8'h00 || ff_x_o !== 4'h0) begin
      n_err++; $display("FAIL b2b_clear: got fail %0d skip %0d ff %h/%h expected all 0",
                        fail_cnt_o, skip_cnt_o, ff_vec_o, ff_x_o);
    end
    n_vec++;
    if ({busy_o, done_o, pass_o} !== 3'b100) begin
      n_err++; $display("FAIL b2b_flags: got %b expected 100", {busy_o, done_o, pass_o});
    end
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (cyc !== 2048 || pass_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_done: got cycles %0d pass %b expected 2048 1", cyc, pass_o);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int cyc;
    mode = 0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, done_o, pass_o} !== 3'b000 || fail_cnt_o !== 9'd0 || skip_cnt_o !== 9'd0) begin
      n_err++; $display("FAIL midrst_outputs: got flags %b skip %0d fail %0d expected 000 0 0",
                        {busy_o, done_o, pass_o}, skip_cnt_o, fail_cnt_o);
    end
    n_vec++;
    if (uut_in_o !== 8'h00) begin n_err++; $display("FAIL midrst_uut: got %h expected 00", uut_in_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_sweep(cyc);
    n_vec++;
    if (cyc !== 2048 || pass_o !== 1'b1 || fail_cnt_o !== 9'd0 || skip_cnt_o !== 9'd136) begin
      n_err++; $display("FAIL midrst_rerun: got cycles %0d pass %b fail %0d skip %0d expected 2048 1 0 136",
                        cyc, pass_o, fail_cnt_o, skip_cnt_o);
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    logic busy_at_10;
    mode = 0;
    busy_at_10 = 1'b0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) busy_at_10 = busy_o;
      start_i = (cyc == 10 || cyc == 1000);
    end
    start_i = 1'b0;
    n_vec++;
    if (busy_at_10 !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b expected 1", busy_at_10); end
    n_vec++;
    if (cyc !== 2048 || pass_o !== 1'b1 || skip_cnt_o !== 9'd136) begin
      n_err++; $display("FAIL ign_done: got cycles %0d pass %b skip %0d expected 2048 1 136",
                        cyc, pass_o, skip_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_skolem_netlist();
    test_const_witness(1, 4'd1, X1_CYC, X1_FAIL, X1_SKIP, 8'h01);
    test_x_zero();
    test_const_witness(3, 4'd3, X3_CYC, X3_FAIL, X3_SKIP, 8'h03);
    test_const_witness(4, 4'd7, X7_CYC, X7_FAIL, X7_SKIP, 8'h07);
    test_back_to_back();
    test_reset_mid_sweep();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
